// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: FSM encoding and default geometry.
package cache_refill_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_OFF_W      = $clog2(DEF_LINE_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRefill,
        StDone
    } state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Core, main-memory and cache-array signals seen by the refill controller.
interface cache_refill_ctrl_if
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] WordAddress;
    logic [DATA_W-1:0] WriteData;
    logic              Hit;
    logic              stall;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemAck;
    logic              LineWe;
    logic [OFF_W-1:0]  LineWordSel;
    logic [DATA_W-1:0] LineWData;
    logic              TagWe;

    // The controller masters the memory bus and the cache arrays.
    modport master (
        input  MemRead, MemWrite, WordAddress, WriteData, Hit, MemRData, MemAck,
        output stall, MemReq, MemWe, MemAddr, MemWData, LineWe, LineWordSel, LineWData, TagWe
    );

    modport slave (
        output MemRead, MemWrite, WordAddress, WriteData, Hit, MemRData, MemAck,
        input  stall, MemReq, MemWe, MemAddr, MemWData, LineWe, LineWordSel, LineWData, TagWe
    );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Write-through, no-write-allocate cache controller: forwards stores to memory and
// refills a whole line (word 0 first) on a read miss.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input logic                  CLK,
    input logic                  RST,
    cache_refill_ctrl_if.master  bus
);
    localparam int unsigned      OFF_W     = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_hit;
    logic [OFF_W-1:0]  r_cnt;
    logic              w_write_go;
    logic              w_refill_go;

    assign w_write_go  = (r_state == StIdle) && bus.MemWrite;
    assign w_refill_go = (r_state == StIdle) && !bus.MemWrite && bus.MemRead && !bus.Hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_data  <= '0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_write_go) begin
                r_addr <= bus.WordAddress;
                r_data <= bus.WriteData;
                r_hit  <= bus.Hit;
            end else if (w_refill_go) begin
                r_addr <= {bus.WordAddress[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_cnt  <= '0;
            end else if ((r_state == StRefill) && bus.MemAck) begin
                // Power-of-two line: the last ack wraps the counter back to 0.
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.stall       = 1'b0;
        bus.MemReq      = 1'b0;
        bus.MemWe       = 1'b0;
        bus.MemAddr     = r_addr;
        bus.MemWData    = r_data;
        bus.LineWe      = 1'b0;
        bus.LineWordSel = r_cnt;
        bus.LineWData   = r_data;
        bus.TagWe       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_write_go) begin
                    w_next = StWrite;
                end else if (w_refill_go) begin
                    w_next = StRefill;
                end
                bus.stall = w_write_go || w_refill_go;
            end
            StWrite: begin
                bus.stall       = 1'b1;
                bus.MemReq      = 1'b1;
                bus.MemWe       = 1'b1;
                bus.LineWordSel = r_addr[OFF_W-1:0];
                if (bus.MemAck) begin
                    w_next     = StDone;
                    bus.LineWe = r_hit;
                end
            end
            StRefill: begin
                bus.stall     = 1'b1;
                bus.MemReq    = 1'b1;
                bus.MemAddr   = {r_addr[ADDR_W-1:OFF_W], r_cnt};
                bus.LineWData = bus.MemRData;
                if (bus.MemAck) begin
                    bus.LineWe = 1'b1;
                    if (r_cnt == LAST_WORD) begin
                        bus.TagWe = 1'b1;
                        w_next    = StDone;
                    end
                end
            end
            StDone: begin
                w_next = StIdle;
            end
            default: begin
                w_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: drives core/memory traffic and checks each cycle
// against per-transaction expectations derived from the cache policy.
module tb_cache_refill_ctrl;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    cache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

    cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive_idle();
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.Hit         = 1'b0;
        bus.MemAck      = 1'b0;
        bus.WordAddress = AW'($urandom);
        bus.WriteData   = $urandom;
        bus.MemRData    = $urandom;
    endtask

    // Junk on the core inputs while busy: the controller must not look at them.
    task automatic scramble();
        bus.MemRead     = 1'($urandom);
        bus.MemWrite    = 1'($urandom);
        bus.Hit         = 1'($urandom);
        bus.WordAddress = AW'($urandom);
        bus.WriteData   = $urandom;
    endtask

    task automatic expect_quiet(input string tag);
        check_eq({tag, ".stall"},  64'(bus.stall),  64'(0));
        check_eq({tag, ".MemReq"}, 64'(bus.MemReq), 64'(0));
        check_eq({tag, ".LineWe"}, 64'(bus.LineWe), 64'(0));
        check_eq({tag, ".TagWe"},  64'(bus.TagWe),  64'(0));
    endtask

    task automatic expect_busy(input string tag, input logic we, input logic [AW-1:0] a);
        check_eq({tag, ".stall"},   64'(bus.stall),   64'(1));
        check_eq({tag, ".MemReq"},  64'(bus.MemReq),  64'(1));
        check_eq({tag, ".MemWe"},   64'(bus.MemWe),   64'(we));
        check_eq({tag, ".MemAddr"}, 64'(bus.MemAddr), 64'(a));
    endtask

    // DONE cycle (requests ignored, stray ack ignored) followed by one quiet IDLE cycle.
    task automatic finish_done();
        bus.MemRead  = 1'($urandom);
        bus.MemWrite = 1'($urandom);
        bus.Hit      = 1'b0;
        bus.MemAck   = 1'($urandom);
        sample();
        expect_quiet("done");
        tick();
        drive_idle();
        sample();
        expect_quiet("idle");
        tick();
    endtask

    task automatic do_read_hit(input logic [AW-1:0] a);
        drive_idle();
        bus.MemRead     = 1'b1;
        bus.Hit         = 1'b1;
        bus.WordAddress = a;
        sample();
        expect_quiet("rdhit");
        tick();
        drive_idle();
        sample();
        expect_quiet("rdhit.after");
        tick();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hit,
                            input logic rd, input int unsigned wmax);
        int unsigned      w;
        logic [AW-1:0]    off;
        off = a & AW'(LW - 1);
        drive_idle();
        bus.MemWrite    = 1'b1;
        bus.MemRead     = rd;
        bus.Hit         = hit;
        bus.WordAddress = a;
        bus.WriteData   = d;
        sample();
        check_eq("wr.entry.stall",  64'(bus.stall),  64'(1));
        check_eq("wr.entry.MemReq", 64'(bus.MemReq), 64'(0));
        tick();
        w = $urandom_range(0, wmax);
        for (int i = 0; i <= int'(w); i++) begin
            scramble();
            bus.MemAck = (i == int'(w));
            sample();
            expect_busy("wr", 1'b1, a);
            check_eq("wr.MemWData", 64'(bus.MemWData), 64'(d));
            check_eq("wr.LineWe", 64'(bus.LineWe), 64'((i == int'(w)) && hit));
            check_eq("wr.TagWe", 64'(bus.TagWe), 64'(0));
            if ((i == int'(w)) && hit) begin
                check_eq("wr.LineWordSel", 64'(bus.LineWordSel), 64'(off));
                check_eq("wr.LineWData", 64'(bus.LineWData), 64'(d));
            end
            tick();
        end
        finish_done();
    endtask

    task automatic do_read_miss(input logic [AW-1:0] a, input int unsigned wlo,
                                input int unsigned whi, input int unsigned n_acks);
        int unsigned   w;
        logic [AW-1:0] base;
        logic [DW-1:0] rd;
        base = a & ~AW'(LW - 1);
        drive_idle();
        bus.MemRead     = 1'b1;
        bus.WordAddress = a;
        sample();
        check_eq("rf.entry.stall",  64'(bus.stall),  64'(1));
        check_eq("rf.entry.MemReq", 64'(bus.MemReq), 64'(0));
        tick();
        for (int k = 0; k < int'(n_acks); k++) begin
            w = $urandom_range(wlo, whi);
            for (int i = 0; i <= int'(w); i++) begin
                scramble();
                rd           = $urandom;
                bus.MemRData = rd;
                bus.MemAck   = (i == int'(w));
                sample();
                expect_busy("rf", 1'b0, base + AW'(k));
                check_eq("rf.LineWe", 64'(bus.LineWe), 64'(i == int'(w)));
                if (i == int'(w)) begin
                    check_eq("rf.LineWordSel", 64'(bus.LineWordSel), 64'(k));
                    check_eq("rf.LineWData", 64'(bus.LineWData), 64'(rd));
                    check_eq("rf.TagWe", 64'(bus.TagWe), 64'(k == int'(LW) - 1));
                end else begin
                    check_eq("rf.TagWe.wait", 64'(bus.TagWe), 64'(0));
                end
                tick();
            end
        end
        if (n_acks == LW) begin
            finish_done();
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        RST = 1'b1;
        drive_idle();
        repeat (3) tick();
        sample();
        expect_quiet("reset");
        tick();
        RST = 1'b0;
        sample();
        expect_quiet("post_reset");
        tick();

        do_read_hit(AW'(10'h024));
        do_read_miss(AW'(10'h026), 2, 2, LW);
        do_write(AW'(10'h011), 32'hDEADBEEF, 1'b1, 1'b0, 2);
        do_write(AW'(10'h155), 32'h12345678, 1'b0, 1'b0, 2);
        do_write(AW'(10'h2A3), 32'hCAFEF00D, 1'b0, 1'b1, 2);

        // Reset after two of four refill acks; the stray ack that follows must be ignored.
        do_read_miss(AW'(10'h0B7), 0, 2, 2);
        drive_idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.MemAck = 1'b1;
        sample();
        expect_quiet("rst_mid.stray");
        tick();
        bus.MemAck = 1'b0;
        sample();
        expect_quiet("rst_mid.idle");
        tick();
        do_read_miss(AW'(10'h0B7), 0, 2, LW);

        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom);
            case ($urandom_range(0, 3))
                0:       do_read_hit(ra);
                1:       do_read_miss(ra, 0, 3, LW);
                2:       do_write(ra, $urandom, 1'($urandom), 1'b0, 3);
                default: do_write(ra, $urandom, 1'($urandom), 1'b1, 3);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
